// File: rtl/rgb_pwm_pkg.sv
// rtl/rgb_pwm_pkg.sv - shared mode encoding and breathe state type for the RGB PWM bank
package rgb_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    typedef enum logic {
        BR_UP   = 1'b0,
        BR_DOWN = 1'b1
    } breathe_e;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: shadow/active config, level generator, output compare
module pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  mode_e            wr_mode,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic             period_start,
    input  logic             fade_step,
    input  logic             phase_next,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm_out
);

    mode_e            sh_mode_q, sh_mode_d;
    mode_e            act_mode_q, act_mode_d;
    logic [WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic [WIDTH-1:0] act_duty_q, act_duty_d;
    logic [WIDTH-1:0] level_q, level_d;
    breathe_e         br_q, br_d;
    logic             pwm_q, pwm_d;
    logic             going_up;

    // Shadow takes writes any time; active and level only move on a period boundary,
    // using the shadow contents that become active on that same edge.
    always_comb begin
        sh_mode_d  = sh_mode_q;
        sh_duty_d  = sh_duty_q;
        act_mode_d = act_mode_q;
        act_duty_d = act_duty_q;
        level_d    = level_q;
        br_d       = br_q;
        going_up   = 1'b0;
        pwm_d      = (cnt < level_q);

        if (wr_en) begin
            sh_mode_d = wr_mode;
            sh_duty_d = wr_duty;
        end

        if (period_start) begin
            act_mode_d = sh_mode_q;
            act_duty_d = sh_duty_q;
            case (sh_mode_q)
                MODE_OFF: begin
                    level_d = '0;
                    br_d    = BR_UP;
                end
                MODE_STATIC: begin
                    level_d = sh_duty_q;
                    br_d    = BR_UP;
                end
                MODE_BLINK: begin
                    level_d = phase_next ? sh_duty_q : '0;
                    br_d    = BR_UP;
                end
                default: begin
                    // Breathe: fresh entry restarts at 0, a lowered duty clamps and heads down,
                    // otherwise walk one step per fade step, bouncing between 0 and duty.
                    if (act_mode_q != MODE_BREATHE) begin
                        level_d = '0;
                        br_d    = BR_UP;
                    end else if (sh_duty_q < level_q) begin
                        level_d = sh_duty_q;
                        br_d    = BR_DOWN;
                    end else if (fade_step && (sh_duty_q != '0)) begin
                        going_up = (br_q == BR_UP) ? (level_q < sh_duty_q) : (level_q == '0);
                        if (going_up) begin
                            level_d = level_q + 1'b1;
                            br_d    = ((level_q + 1'b1) == sh_duty_q) ? BR_DOWN : BR_UP;
                        end else begin
                            level_d = level_q - 1'b1;
                            br_d    = (level_q == WIDTH'(1)) ? BR_UP : BR_DOWN;
                        end
                    end
                end
            endcase
        end
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_mode_q  <= MODE_OFF;
            sh_duty_q  <= '0;
            act_mode_q <= MODE_OFF;
            act_duty_q <= '0;
            level_q    <= '0;
            br_q       <= BR_UP;
            pwm_q      <= 1'b0;
        end else begin
            sh_mode_q  <= sh_mode_d;
            sh_duty_q  <= sh_duty_d;
            act_mode_q <= act_mode_d;
            act_duty_q <= act_duty_d;
            level_q    <= level_d;
            br_q       <= br_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/rgb_pwm_bank.sv
// rtl/rgb_pwm_bank.sv - shared PWM timebase and fade/blink sequencer driving NUM_CH channels
module rgb_pwm_bank
    import rgb_pwm_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4,
    parameter int FADE_DIV = 16
) (
    input  logic                                            CLK,
    input  logic                                            RST,
    input  logic                                            cfg_valid,
    output logic                                            cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                      cfg_mode,
    input  logic [WIDTH-1:0]                                cfg_duty,
    output logic [NUM_CH-1:0]                               pwm_out,
    output logic                                            period_start
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FD_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [PS_W-1:0]  presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [FD_W-1:0]  fade_q, fade_d;
    logic             phase_q, phase_d;
    logic             ready_q, ready_d;
    logic             tick;
    logic             fade_step;
    mode_e            cfg_mode_e;

    assign cfg_mode_e = mode_e'(cfg_mode);
    assign cfg_ready  = ready_q;

    // Timebase: prescaler -> counter tick, period boundary, fade step and blink phase.
    always_comb begin
        tick         = (presc_q == PS_W'(PRESCALE - 1));
        period_start = ready_q && tick && (cnt_q == CNT_MAX);
        fade_step    = period_start && (fade_q == FD_W'(FADE_DIV - 1));
        presc_d      = tick ? '0 : presc_q + 1'b1;
        cnt_d        = tick ? cnt_q + 1'b1 : cnt_q;
        fade_d       = fade_q;
        if (period_start) begin
            fade_d = fade_step ? '0 : fade_q + 1'b1;
        end
        phase_d = phase_q ^ fade_step;
        ready_d = 1'b1;
    end

    // Shared state registers with synchronous active-low clear.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            presc_q <= '0;
            cnt_q   <= '0;
            fade_q  <= '0;
            phase_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            fade_q  <= fade_d;
            phase_q <= phase_d;
            ready_q <= ready_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk         (CLK),
            .rst_n       (RST),
            .wr_en       (cfg_valid && ready_q && (int'(cfg_ch) == i)),
            .wr_mode     (cfg_mode_e),
            .wr_duty     (cfg_duty),
            .period_start(period_start),
            .fade_step   (fade_step),
            .phase_next  (phase_d),
            .cnt         (cnt_q),
            .pwm_out     (pwm_out[i])
        );
    end

endmodule
